// File: rtl/cmd_deserializer_pkg.sv
// Shared constants and state encoding for the SD CMD-line deserializer
// and its CRC7 helper.
package cmd_deserializer_pkg;

    localparam int BITS_SHORT  = 48;
    localparam int BITS_LONG   = 136;
    localparam int TIMEOUT_NCR = 64;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        RECEIVE    = 2'd2,
        DONE       = 2'd3
    } state_t;

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), MSB-first, shared by the CMD serializer
// and deserializer.
module crc7_serial
    import cmd_deserializer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift,
    input  logic       data,
    output logic [6:0] crc
);

    logic feedback;

    assign feedback = data ^ crc[6];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (shift) begin
            crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/cmd_deserializer.sv
// Receive side of the SD CMD line: start-bit wait with NCR timeout, 48/136-bit
// frame capture, CRC7 and end-bit check.
module cmd_deserializer
    import cmd_deserializer_pkg::*;
#(
    parameter int BITS_SHORT   = cmd_deserializer_pkg::BITS_SHORT,
    parameter int BITS_LONG    = cmd_deserializer_pkg::BITS_LONG,
    parameter int BITS_COUNTER = 8,
    parameter int TIMEOUT      = cmd_deserializer_pkg::TIMEOUT_NCR,
    parameter int TIMEOUT_BITS = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in,
    input  logic                 long_resp,
    input  logic                 check_crc,
    output logic [BITS_LONG-1:0] out,
    output logic                 complete,
    output logic                 crc_error,
    output logic                 timeout_error,
    output logic                 receiving
);

    // Bit counter value on the edge that samples frame bit k is k+1.
    localparam logic [BITS_COUNTER-1:0] CNT_CRC_LAST = BITS_COUNTER'(9);
    localparam logic [BITS_COUNTER-1:0] CNT_LONG_CRC = BITS_COUNTER'(BITS_LONG - 8);

    state_t                  state, state_next;
    logic [BITS_LONG-1:0]    out_next;
    logic                    complete_next, crc_error_next, timeout_error_next, receiving_next;
    logic                    long_q, long_next, check_q, check_next;
    logic [BITS_COUNTER-1:0] bit_cnt, bit_cnt_next;
    logic [TIMEOUT_BITS-1:0] to_cnt, to_cnt_next, to_cnt_inc;
    logic                    crc_clear, crc_shift;
    logic [6:0]              crc;

    crc7_serial u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (crc_clear),
        .shift (crc_shift),
        .data  (in),
        .crc   (crc)
    );

    assign to_cnt_inc = to_cnt + 1'b1;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next         = state;
        out_next           = out;
        complete_next      = complete;
        crc_error_next     = crc_error;
        timeout_error_next = timeout_error;
        receiving_next     = receiving;
        long_next          = long_q;
        check_next         = check_q;
        bit_cnt_next       = bit_cnt;
        to_cnt_next        = to_cnt;
        crc_clear          = 1'b0;
        crc_shift          = 1'b0;

        case (state)
            IDLE: begin
                crc_clear = 1'b1;
                if (enable) begin
                    state_next         = WAIT_START;
                    long_next          = long_resp;
                    check_next         = check_crc;
                    out_next           = '0;
                    complete_next      = 1'b0;
                    crc_error_next     = 1'b0;
                    timeout_error_next = 1'b0;
                    to_cnt_next        = '0;
                end
            end

            WAIT_START, RECEIVE: begin
                if (!enable) begin
                    state_next         = IDLE;
                    out_next           = '0;
                    complete_next      = 1'b0;
                    crc_error_next     = 1'b0;
                    timeout_error_next = 1'b0;
                    receiving_next     = 1'b0;
                end else if (state == WAIT_START) begin
                    // A start bit beats a timeout landing on the same edge.
                    if (!in) begin
                        state_next     = RECEIVE;
                        out_next       = {out[BITS_LONG-2:0], in};
                        receiving_next = 1'b1;
                        bit_cnt_next   = long_q ? BITS_COUNTER'(BITS_LONG - 1)
                                                : BITS_COUNTER'(BITS_SHORT - 1);
                        crc_shift      = !long_q;
                    end else if (to_cnt_inc == TIMEOUT_BITS'(TIMEOUT)) begin
                        state_next         = DONE;
                        complete_next      = 1'b1;
                        timeout_error_next = 1'b1;
                    end else begin
                        to_cnt_next = to_cnt_inc;
                    end
                end else begin
                    out_next     = {out[BITS_LONG-2:0], in};
                    bit_cnt_next = bit_cnt - 1'b1;
                    crc_shift    = (bit_cnt >= CNT_CRC_LAST) &&
                                   (!long_q || bit_cnt <= CNT_LONG_CRC);
                    if (bit_cnt == BITS_COUNTER'(1)) begin
                        // out[6:0] still holds frame bits 7..1 before this shift.
                        state_next     = DONE;
                        complete_next  = 1'b1;
                        receiving_next = 1'b0;
                        crc_error_next = (check_q && (out[6:0] != crc)) || !in;
                    end
                end
            end

            DONE: begin
                if (!enable) begin
                    state_next         = IDLE;
                    complete_next      = 1'b0;
                    crc_error_next     = 1'b0;
                    timeout_error_next = 1'b0;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            out           <= '0;
            complete      <= 1'b0;
            crc_error     <= 1'b0;
            timeout_error <= 1'b0;
            receiving     <= 1'b0;
            long_q        <= 1'b0;
            check_q       <= 1'b0;
            bit_cnt       <= '0;
            to_cnt        <= '0;
        end else begin
            state         <= state_next;
            out           <= out_next;
            complete      <= complete_next;
            crc_error     <= crc_error_next;
            timeout_error <= timeout_error_next;
            receiving     <= receiving_next;
            long_q        <= long_next;
            check_q       <= check_next;
            bit_cnt       <= bit_cnt_next;
            to_cnt        <= to_cnt_next;
        end
    end

endmodule
